pipe_muldiv: RTL and testbench
==============================

# pipe_muldiv

Iterative multiply/divide unit for the pipelined MIPS core. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and delivers a 64-bit result with HiEn/LoEn write strobes to the write-back stage's Hi/Lo registers. It sits alongside the EX-stage ALU. The hazard unit uses `busy` to stall MFHI/MFLO and any further mult/div issue while an operation is in flight.

## Interface
- No parameters.
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- start  input  1  issue strobe; sampled only while busy=0
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are a no-op
- op_a  input  32  rs value: multiplicand, dividend, or MTHI/MTLO source
- op_b  input  32  rt value: multiplier or divisor
- flush  input  1  abort any in-flight operation (branch/exception squash)
- busy  output  1  high while a MULT/MULTU/DIV/DIVU is in progress
- result  output  64  {hi, lo} for mult/div; {32'b0, op_a} for MTHI/MTLO
- hi_en  output  1  one-cycle write strobe for Hi
- lo_en  output  1  one-cycle write strobe for Lo

## Operation
- States: IDLE, CALC, FIX, DONE. Reset forces IDLE and clears the working registers.
- Reset values: busy=0, hi_en=0, lo_en=0, result=0.
- IDLE, start=1, op ∈ {000..011}:
  - Latch op_a, op_b and op.
  - Clear the 5-bit counter.
  - Go to CALC.
- IDLE, start=1, op=MTHI: next cycle, result={32'b0, op_a}, hi_en=1, lo_en=0. State stays IDLE; busy stays 0.
- IDLE, start=1, op=MTLO: same as MTHI, but lo_en=1 and hi_en=0.
- start with op 110/111: ignored.
- Signed ops:
  - Operands are converted to magnitudes at latch time.
  - The result sign is recorded: product sign = a[31]^b[31]; quotient sign = a[31]^b[31]; remainder sign = a[31].
- CALC runs 32 iterations, one bit per cycle:
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring division producing a 32-bit quotient and a 32-bit remainder.
  - After counter=31, go to FIX.
- FIX:
  - Apply two's-complement negation where the recorded sign requires it.
  - Multiply: negate the full 64-bit product.
  - Divide: negate the quotient and the remainder independently.
  - Go to DONE.
- DONE:
  - result is registered; hi_en=lo_en=1 for exactly this cycle.
  - Mult: result = 64-bit product.
  - Div: result = {remainder, quotient}.
  - Go to IDLE.
- Division by zero (DIV and DIVU): quotient=32'hFFFFFFFF, remainder=op_a. No trap.
- DIV 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0. This falls out of magnitude arithmetic with 32-bit wrap.
- result holds its last value between strobes. Consumers use it only when hi_en or lo_en is high.

## Timing
- The start cycle is cycle 0.
- Mult/div:
  - CALC occupies cycles 1–32, FIX cycle 33, DONE cycle 34.
  - hi_en/lo_en are high in cycle 34 only.
  - busy=1 in cycles 1–34 and is 0 in cycle 35.
  - A new start is accepted in cycle 35 at the earliest.
- MTHI/MTLO: the strobe appears in cycle 1. Back-to-back MTHI/MTLO issues are accepted every cycle.
- start while busy=1: ignored. There is no queueing, and the latched operands are unaffected.
- flush:
  - Takes effect at the next edge: state goes to IDLE and busy=0.
  - No strobe is produced for the aborted op.
  - Flush asserted in the DONE cycle does not suppress that cycle's strobe, which is already registered.
  - flush and start in the same cycle: flush wins and start is ignored. This includes MTHI/MTLO.
- reset asserted mid-operation: IDLE at the next edge, all outputs 0, no strobe.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- MULT with op_a=0xFFFFFFFD (-3), op_b=5 -> in cycle 34: result=0xFFFFFFFF_FFFFFFF1, hi_en=lo_en=1; busy high for cycles 1–34.
- MULTU with op_a=op_b=0xFFFFFFFF -> result=0xFFFFFFFE_00000001.
- DIV with op_a=0xFFFFFFF9 (-7), op_b=2 -> result=0xFFFFFFFF_FFFFFFFD, i.e. remainder -1, quotient -3.
- DIVU with op_a=0x12345678, op_b=0 -> result=0x12345678_FFFFFFFF.
- MTHI with op_a=0xCAFEBABE, then MTLO with op_a=0x1 on the next cycle:
  - cycle 1: result=0x00000000_CAFEBABE, hi_en=1, lo_en=0.
  - cycle 2: result=0x00000000_00000001, lo_en=1, hi_en=0.
- Abort and ignore cases:
  - Start DIVU 100/7; assert flush in cycle 10 -> busy=0 in cycle 11 and no strobe ever appears.
  - Start MULT 3*4; assert start MTLO in cycle 5 -> the MTLO is ignored, and in cycle 34 result=0x00000000_0000000C.
  - Assert reset in cycle 20 of a MULT -> all outputs 0 from cycle 21, no strobe.

Source files
------------

// File: rtl/pipe_muldiv.sv
// rtl/pipe_muldiv.sv - iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit for the EX stage
// Signed operands run on magnitudes for 32 cycles; the signs are restored in FIX.
module pipe_muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        busy,
  output logic [63:0] result,
  output logic        hi_en,
  output logic        lo_en
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state, state_d;
  logic [4:0]  cnt, cnt_d;
  logic [63:0] acc, acc_d;
  logic [31:0] opnd, opnd_d;
  logic        is_div, is_div_d;
  logic        sgn_q, sgn_q_d;
  logic        sgn_r, sgn_r_d;
  logic        busy_d, hi_en_d, lo_en_d;
  logic [63:0] result_d;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] div_next;
  logic [63:0] fix_mul, fix_div;

  // op[0]=0 selects the signed variants (MULT, DIV)
  assign a_neg = ~op[0] & op_a[31];
  assign b_neg = ~op[0] & op_b[31];
  assign a_mag = a_neg ? 32'd0 - op_a : op_a;
  assign b_mag = b_neg ? 32'd0 - op_b : op_b;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign mul_next = {mul_sum, acc[31:1]};

  assign div_shift = {acc[63:32], acc[31]};
  assign div_ge    = div_shift >= {1'b0, opnd};
  assign div_sub   = div_shift[31:0] - opnd;
  assign div_next  = div_ge ? {div_sub, acc[30:0], 1'b1}
                            : {div_shift[31:0], acc[30:0], 1'b0};

  assign fix_mul = sgn_q ? 64'd0 - acc : acc;
  assign fix_div = {sgn_r ? 32'd0 - acc[63:32] : acc[63:32],
                    sgn_q ? 32'd0 - acc[31:0]  : acc[31:0]};

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    acc_d    = acc;
    opnd_d   = opnd;
    is_div_d = is_div;
    sgn_q_d  = sgn_q;
    sgn_r_d  = sgn_r;
    result_d = result;
    hi_en_d  = 1'b0;
    lo_en_d  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              is_div_d = op[1];
              opnd_d   = op[1] ? b_mag : a_mag;
              acc_d    = {32'd0, op[1] ? a_mag : b_mag};
              // divide-by-zero keeps the all-ones quotient unnegated
              sgn_q_d  = (a_neg ^ b_neg) & ~(op[1] & (op_b == 32'd0));
              sgn_r_d  = a_neg;
              cnt_d    = 5'd0;
              state_d  = CALC;
            end
            3'd4: begin
              result_d = {32'd0, op_a};
              hi_en_d  = 1'b1;
            end
            3'd5: begin
              result_d = {32'd0, op_a};
              lo_en_d  = 1'b1;
            end
            default: ;
          endcase
        end
      end
      CALC: begin
        acc_d = is_div ? div_next : mul_next;
        cnt_d = cnt + 5'd1;
        if (cnt == 5'd31)
          state_d = FIX;
      end
      FIX: begin
        result_d = is_div ? fix_div : fix_mul;
        hi_en_d  = 1'b1;
        lo_en_d  = 1'b1;
        state_d  = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d  = IDLE;
      result_d = result;
      hi_en_d  = 1'b0;
      lo_en_d  = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      acc    <= 64'd0;
      opnd   <= 32'd0;
      is_div <= 1'b0;
      sgn_q  <= 1'b0;
      sgn_r  <= 1'b0;
      busy   <= 1'b0;
      result <= 64'd0;
      hi_en  <= 1'b0;
      lo_en  <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      acc    <= acc_d;
      opnd   <= opnd_d;
      is_div <= is_div_d;
      sgn_q  <= sgn_q_d;
      sgn_r  <= sgn_r_d;
      busy   <= busy_d;
      result <= result_d;
      hi_en  <= hi_en_d;
      lo_en  <= lo_en_d;
    end
  end

endmodule

// File: tb/tb_pipe_muldiv.sv
// tb/tb_pipe_muldiv.sv - bench for pipe_muldiv
// Cycle-level reference model compared every cycle, plus directed literal cases.
module tb_pipe_muldiv;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  op;
  logic [31:0] op_a, op_b;
  logic        busy, hi_en, lo_en;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  pipe_muldiv dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .flush(flush), .busy(busy), .result(result), .hi_en(hi_en), .lo_en(lo_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: return sa * sb;
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  // phase = cycle number since the accepted start (0 when idle)
  int          phase, np;
  logic [63:0] pend, m_result;
  logic        m_busy, m_hi, m_lo;

  always @(posedge clk) begin
    if (reset) begin
      phase = 0; m_result = 64'd0; m_hi = 1'b0; m_lo = 1'b0; m_busy = 1'b0;
    end else begin
      m_hi = 1'b0; m_lo = 1'b0; np = 0;
      if (flush) begin
        np = 0;
      end else if (phase != 0) begin
        np = (phase == 34) ? 0 : phase + 1;
        if (np == 34) begin
          m_hi = 1'b1; m_lo = 1'b1; m_result = pend;
        end
      end else if (start) begin
        if (op < 3'd4) begin
          np = 1;
          pend = ref_op(op, op_a, op_b);
        end else if (op == 3'd4) begin
          m_result = {32'd0, op_a}; m_hi = 1'b1;
        end else if (op == 3'd5) begin
          m_result = {32'd0, op_a}; m_lo = 1'b1;
        end
      end
      phase = np;
      m_busy = (np != 0);
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("busy", {63'd0, busy}, {63'd0, m_busy});
      chk("hi_en", {63'd0, hi_en}, {63'd0, m_hi});
      chk("lo_en", {63'd0, lo_en}, {63'd0, m_lo});
      chk("result", result, m_result);
    end
  end

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic wait_strobe(input int cur, output int k);
    k = cur;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      k++;
    end while (!(hi_en || lo_en) && k < 60);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; op_a = a; op_b = b;
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int k;
    issue(o, a, b);
    wait_strobe(0, k);
    chk({name, "_cycle"}, 64'(k), 64'd34);
    chk({name, "_result"}, result, exp);
    adv(3);
  endtask

  task automatic no_strobe(input string name, input int n);
    int s;
    s = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (hi_en || lo_en) s++;
    end
    chk(name, 64'(s), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  int k;

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; op_a = 32'd0; op_b = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_strobes", {62'd0, hi_en, lo_en}, 64'd0);
    chk("reset_result", result, 64'd0);
    chk_en = 1'b1;

    chk("model_mult", ref_op(3'd0, 32'hFFFFFFFD, 32'd5), 64'hFFFFFFFF_FFFFFFF1);
    chk("model_div", ref_op(3'd2, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
    chk("model_divu0", ref_op(3'd3, 32'h12345678, 32'd0), 64'h12345678_FFFFFFFF);
    chk("model_divovf", ref_op(3'd2, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);

    run_op("mult", 3'd0, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1);
    run_op("multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    run_op("div", 3'd2, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    run_op("divu0", 3'd3, 32'h12345678, 32'd0, 64'h12345678_FFFFFFFF);
    run_op("divovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    run_op("div0s", 3'd2, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF);

    issue(3'd4, 32'hCAFEBABE, 32'd0);
    @(posedge clk); #1;
    chk("mthi_result", result, 64'h00000000_CAFEBABE);
    chk("mthi_strobes", {62'd0, hi_en, lo_en}, 64'd2);
    op = 3'd5; op_a = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mtlo_result", result, 64'h00000000_00000001);
    chk("mtlo_strobes", {62'd0, hi_en, lo_en}, 64'd1);
    adv(3);

    issue(3'd3, 32'd100, 32'd7);
    adv(10);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    no_strobe("flush_no_strobe", 40);

    issue(3'd0, 32'd3, 32'd4);
    adv(5);
    start = 1'b1; op = 3'd5; op_a = 32'h0000FFFF;
    wait_strobe(5, k);
    chk("busy_mtlo_cycle", 64'(k), 64'd34);
    chk("busy_mtlo_result", result, 64'h00000000_0000000C);
    adv(3);

    issue(3'd0, 32'd7, 32'd9);
    adv(20);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_outputs", {61'd0, busy, hi_en, lo_en}, 64'd0);
    chk("rst_result", result, 64'd0);
    no_strobe("rst_no_strobe", 40);

    repeat (4000) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 3) == 0);
      op    = 3'($urandom_range(0, 7));
      op_a  = pick();
      op_b  = pick();
    end
    @(negedge clk);
    reset = 1'b0; flush = 1'b0; start = 1'b0;
    adv(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
